// File: rtl/comp_arb_pkg.sv
// Shared types and constants for the comp unit arbiter.
package comp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Requester ids as they appear on RESP_ID
  localparam logic REQ_ID_SUB = 1'b0;  // ALU SUB operand path
  localparam logic REQ_ID_BR  = 1'b1;  // branch-offset negation path

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Purely combinational so it can front any shared unit.
module rr_arb2
  import comp_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_id,
  output logic       grant_valid
);

  // Tie goes to the port that did not win last time; a lone requester always wins
  always_comb begin
    grant_valid = |valid;
    grant_id    = REQ_ID_SUB;
    if (valid[0] && valid[1]) begin
      grant_id = ~last_grant;
    end else if (valid[1]) begin
      grant_id = REQ_ID_BR;
    end
  end

endmodule

// File: rtl/comp_arbiter.sv
// Arbitrates two requesters onto the shared two's-complement unit, one op in flight.
// The unit's operand is driven from a register and held for SETTLE_CYCLES before
// its result is captured; SETTLE_CYCLES must be at least 1.
module comp_arbiter
  import comp_arb_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0_VALID,
  input  logic [WIDTH-1:0] REQ0_OPERAND,
  output logic             REQ0_READY,
  input  logic             REQ1_VALID,
  input  logic [WIDTH-1:0] REQ1_OPERAND,
  output logic             REQ1_READY,
  output logic [WIDTH-1:0] COMP_OPERAND_OUT,
  input  logic [WIDTH-1:0] COMP_RESULT,
  output logic             RESP_VALID,
  output logic             RESP_ID,
  output logic [WIDTH-1:0] RESP_DATA,
  output logic             RESP_OVF,
  input  logic             RESP_READY,
  output logic             BUSY
);

  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             id_q, id_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             grant_id;
  logic             grant_valid;
  logic             accept;
  logic [WIDTH-1:0] sel_operand;

  rr_arb2 u_rr_arb2 (
    .valid       ({REQ1_VALID, REQ0_VALID}),
    .last_grant  (last_grant_q),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign accept      = (state_q == IDLE) && grant_valid;
  assign sel_operand = (grant_id == REQ_ID_BR) ? REQ1_OPERAND : REQ0_OPERAND;

  assign REQ0_READY       = accept && (grant_id == REQ_ID_SUB);
  assign REQ1_READY       = accept && (grant_id == REQ_ID_BR);
  assign COMP_OPERAND_OUT = operand_q;
  assign RESP_VALID       = (state_q == HOLD);
  assign RESP_ID          = id_q;
  assign RESP_DATA        = data_q;
  assign RESP_OVF         = ovf_q;
  assign BUSY             = (state_q != IDLE);

  // Next state: accept in IDLE, count down the settle window, hold until consumed
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    operand_d    = operand_q;
    id_d         = id_q;
    ovf_d        = ovf_q;
    data_d       = data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          operand_d    = sel_operand;
          id_d         = grant_id;
          ovf_d        = (sel_operand == MIN_NEG);
          last_grant_d = grant_id;
          cnt_d        = CNT_INIT;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          data_d  = COMP_RESULT;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (RESP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset makes port 0 win the first tie
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= REQ_ID_BR;
      operand_q    <= '0;
      id_q         <= 1'b0;
      ovf_q        <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      operand_q    <= operand_d;
      id_q         <= id_d;
      ovf_q        <= ovf_d;
      data_q       <= data_d;
    end
  end

endmodule

// File: tb/tb_comp_arbiter.sv
// Directed bench for comp_arbiter: one instance with a 1-cycle settle window and
// one with a 3-cycle window, each wired to a behavioural negation unit.
module tb_comp_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ0_VALID, REQ1_VALID, RESP_READY;
  logic [7:0] REQ0_OPERAND, REQ1_OPERAND;
  logic       REQ0_READY, REQ1_READY, RESP_VALID, RESP_ID, RESP_OVF, BUSY;
  logic [7:0] COMP_OPERAND_OUT, COMP_RESULT, RESP_DATA;

  logic       s3_req0_valid, s3_req1_valid, s3_resp_ready;
  logic [7:0] s3_req0_operand, s3_req1_operand;
  logic       s3_req0_ready, s3_req1_ready, s3_resp_valid, s3_resp_id, s3_resp_ovf, s3_busy;
  logic [7:0] s3_comp_op, s3_comp_res, s3_resp_data;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Shared negation unit models with a small propagation delay
  assign #1 COMP_RESULT = ~COMP_OPERAND_OUT + 8'd1;
  assign #1 s3_comp_res = ~s3_comp_op + 8'd1;

  comp_arbiter #(.WIDTH(8), .SETTLE_CYCLES(1)) dut (
    .CLK (CLK), .RESET (RESET),
    .REQ0_VALID (REQ0_VALID), .REQ0_OPERAND (REQ0_OPERAND), .REQ0_READY (REQ0_READY),
    .REQ1_VALID (REQ1_VALID), .REQ1_OPERAND (REQ1_OPERAND), .REQ1_READY (REQ1_READY),
    .COMP_OPERAND_OUT (COMP_OPERAND_OUT), .COMP_RESULT (COMP_RESULT),
    .RESP_VALID (RESP_VALID), .RESP_ID (RESP_ID), .RESP_DATA (RESP_DATA),
    .RESP_OVF (RESP_OVF), .RESP_READY (RESP_READY), .BUSY (BUSY)
  );

  comp_arbiter #(.WIDTH(8), .SETTLE_CYCLES(3)) dut3 (
    .CLK (CLK), .RESET (RESET),
    .REQ0_VALID (s3_req0_valid), .REQ0_OPERAND (s3_req0_operand), .REQ0_READY (s3_req0_ready),
    .REQ1_VALID (s3_req1_valid), .REQ1_OPERAND (s3_req1_operand), .REQ1_READY (s3_req1_ready),
    .COMP_OPERAND_OUT (s3_comp_op), .COMP_RESULT (s3_comp_res),
    .RESP_VALID (s3_resp_valid), .RESP_ID (s3_resp_id), .RESP_DATA (s3_resp_data),
    .RESP_OVF (s3_resp_ovf), .RESP_READY (s3_resp_ready), .BUSY (s3_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change right after the falling edge; checks run 1ns later
  task automatic nc();
    @(negedge CLK);
  endtask

  initial begin
    logic [7:0] t3_op  [3];
    logic [7:0] t3_res [3];
    logic       t3_ovf [3];
    t3_op[0] = 8'h00; t3_res[0] = 8'h00; t3_ovf[0] = 1'b0;
    t3_op[1] = 8'h80; t3_res[1] = 8'h80; t3_ovf[1] = 1'b1;
    t3_op[2] = 8'hFF; t3_res[2] = 8'h01; t3_ovf[2] = 1'b0;

    RESET = 1'b1;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; RESP_READY = 1'b0;
    REQ0_OPERAND = 8'h00; REQ1_OPERAND = 8'h00;
    s3_req0_valid = 1'b0; s3_req1_valid = 1'b0; s3_resp_ready = 1'b0;
    s3_req0_operand = 8'h00; s3_req1_operand = 8'h00;

    // Reset state
    nc(); nc(); #1;
    chk("rst_op",    32'(COMP_OPERAND_OUT), 32'h00);
    chk("rst_valid", 32'(RESP_VALID), 0);
    chk("rst_data",  32'(RESP_DATA), 32'h00);
    chk("rst_id",    32'(RESP_ID), 0);
    chk("rst_ovf",   32'(RESP_OVF), 0);
    chk("rst_busy",  32'(BUSY), 0);
    chk("rst_rdy0",  32'(REQ0_READY), 0);
    chk("rst_rdy1",  32'(REQ1_READY), 0);

    // 1: single op from port 0, response two cycles after handshake
    nc(); RESET = 1'b0; REQ0_VALID = 1'b1; REQ0_OPERAND = 8'h05; RESP_READY = 1'b1; #1;
    chk("t1_rdy0", 32'(REQ0_READY), 1);
    chk("t1_rdy1", 32'(REQ1_READY), 0);
    chk("t1_busy_idle", 32'(BUSY), 0);
    nc(); REQ0_VALID = 1'b0; #1;
    chk("t1_busy",   32'(BUSY), 1);
    chk("t1_early",  32'(RESP_VALID), 0);
    chk("t1_opout",  32'(COMP_OPERAND_OUT), 32'h05);
    nc(); #1;
    chk("t1_valid",  32'(RESP_VALID), 1);
    chk("t1_data",   32'(RESP_DATA), 32'hFB);
    chk("t1_id",     32'(RESP_ID), 0);
    chk("t1_ovf",    32'(RESP_OVF), 0);
    nc(); #1;
    chk("t1_done",   32'(RESP_VALID), 0);
    chk("t1_idle",   32'(BUSY), 0);

    // 2: both request together after reset -> port 0, then 1, then 0
    nc(); RESET = 1'b1;
    nc(); RESET = 1'b0;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; REQ0_OPERAND = 8'h01; REQ1_OPERAND = 8'h01; #1;
    chk("t2_a_rdy0", 32'(REQ0_READY), 1);
    chk("t2_a_rdy1", 32'(REQ1_READY), 0);
    nc(); #1;
    chk("t2_settle_rdy1", 32'(REQ1_READY), 0);
    chk("t2_settle_rdy0", 32'(REQ0_READY), 0);
    nc(); #1;
    chk("t2_a_valid", 32'(RESP_VALID), 1);
    chk("t2_a_id",    32'(RESP_ID), 0);
    chk("t2_a_data",  32'(RESP_DATA), 32'hFF);
    chk("t2_hold_rdy1", 32'(REQ1_READY), 0);
    nc(); #1;
    chk("t2_b_rdy1", 32'(REQ1_READY), 1);
    chk("t2_b_rdy0", 32'(REQ0_READY), 0);
    nc(); #1;
    chk("t2_b_opout", 32'(COMP_OPERAND_OUT), 32'h01);
    nc(); #1;
    chk("t2_b_valid", 32'(RESP_VALID), 1);
    chk("t2_b_id",    32'(RESP_ID), 1);
    chk("t2_b_data",  32'(RESP_DATA), 32'hFF);
    nc(); #1;
    chk("t2_c_rdy0", 32'(REQ0_READY), 1);
    chk("t2_c_rdy1", 32'(REQ1_READY), 0);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;

    // 3: boundary operands from lone port 1
    for (int i = 0; i < 3; i++) begin
      nc(); REQ1_VALID = 1'b1; REQ1_OPERAND = t3_op[i]; #1;
      chk("t3_rdy1", 32'(REQ1_READY), 1);
      nc(); REQ1_VALID = 1'b0;
      nc(); #1;
      chk("t3_valid", 32'(RESP_VALID), 1);
      chk("t3_data",  32'(RESP_DATA), 32'(t3_res[i]));
      chk("t3_ovf",   32'(RESP_OVF), 32'(t3_ovf[i]));
      chk("t3_id",    32'(RESP_ID), 1);
    end

    // 4: consumer stalls in HOLD while port 1 waits with a changing operand
    nc(); REQ0_VALID = 1'b1; REQ0_OPERAND = 8'h22; RESP_READY = 1'b0;
    REQ1_VALID = 1'b1; REQ1_OPERAND = 8'h99; #1;
    chk("t4_rdy0", 32'(REQ0_READY), 1);
    chk("t4_rdy1", 32'(REQ1_READY), 0);
    nc(); REQ0_VALID = 1'b0;
    for (int k = 0; k < 5; k++) begin
      nc(); REQ1_OPERAND = 8'(8'h60 + k); #1;
      chk("t4_valid", 32'(RESP_VALID), 1);
      chk("t4_data",  32'(RESP_DATA), 32'hDE);
      chk("t4_id",    32'(RESP_ID), 0);
      chk("t4_ovf",   32'(RESP_OVF), 0);
      chk("t4_rdy0",  32'(REQ0_READY), 0);
      chk("t4_rdy1",  32'(REQ1_READY), 0);
      chk("t4_busy",  32'(BUSY), 1);
    end
    nc(); RESP_READY = 1'b1; REQ1_OPERAND = 8'h10; #1;
    chk("t4_release_rdy1", 32'(REQ1_READY), 0);
    chk("t4_release_valid", 32'(RESP_VALID), 1);
    nc(); #1;
    chk("t4_next_rdy1", 32'(REQ1_READY), 1);
    nc(); REQ1_VALID = 1'b0; #1;
    chk("t4_next_opout", 32'(COMP_OPERAND_OUT), 32'h10);
    nc(); #1;
    chk("t4_next_data", 32'(RESP_DATA), 32'hF0);
    chk("t4_next_id",   32'(RESP_ID), 1);
    nc();

    // 5: reset during SETTLE, then during HOLD
    REQ0_VALID = 1'b1; REQ0_OPERAND = 8'h33; #1;
    chk("t5_a_rdy0", 32'(REQ0_READY), 1);
    nc(); REQ0_VALID = 1'b0; RESET = 1'b1; #1;
    chk("t5_a_busy", 32'(BUSY), 1);
    nc(); RESET = 1'b0; RESP_READY = 1'b0;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; REQ0_OPERAND = 8'h44; REQ1_OPERAND = 8'h44; #1;
    chk("t5_a_busy0",  32'(BUSY), 0);
    chk("t5_a_valid0", 32'(RESP_VALID), 0);
    chk("t5_a_opout0", 32'(COMP_OPERAND_OUT), 32'h00);
    chk("t5_a_data0",  32'(RESP_DATA), 32'h00);
    chk("t5_a_id0",    32'(RESP_ID), 0);
    chk("t5_a_ovf0",   32'(RESP_OVF), 0);
    chk("t5_a_rdy0",   32'(REQ0_READY), 1);
    chk("t5_a_rdy1",   32'(REQ1_READY), 0);
    nc(); REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    nc(); #1;
    chk("t5_b_valid", 32'(RESP_VALID), 1);
    chk("t5_b_data",  32'(RESP_DATA), 32'hBC);
    RESET = 1'b1;
    nc(); RESET = 1'b0; REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; #1;
    chk("t5_b_valid0", 32'(RESP_VALID), 0);
    chk("t5_b_busy0",  32'(BUSY), 0);
    chk("t5_b_data0",  32'(RESP_DATA), 32'h00);
    chk("t5_b_opout0", 32'(COMP_OPERAND_OUT), 32'h00);
    chk("t5_b_rdy0",   32'(REQ0_READY), 1);
    chk("t5_b_rdy1",   32'(REQ1_READY), 0);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; RESP_READY = 1'b1;

    // 6: three-cycle settle window on the second instance
    nc(); s3_req0_valid = 1'b1; s3_req0_operand = 8'h07; s3_resp_ready = 1'b1; #1;
    chk("t6_rdy0", 32'(s3_req0_ready), 1);
    nc(); s3_req0_valid = 1'b0; #1;
    chk("t6_op_t1",  32'(s3_comp_op), 32'h07);
    chk("t6_vld_t1", 32'(s3_resp_valid), 0);
    nc(); #1;
    chk("t6_op_t2",  32'(s3_comp_op), 32'h07);
    chk("t6_vld_t2", 32'(s3_resp_valid), 0);
    nc(); #1;
    chk("t6_op_t3",  32'(s3_comp_op), 32'h07);
    chk("t6_vld_t3", 32'(s3_resp_valid), 0);
    nc(); #1;
    chk("t6_op_t4",  32'(s3_comp_op), 32'h07);
    chk("t6_vld_t4", 32'(s3_resp_valid), 1);
    chk("t6_data",   32'(s3_resp_data), 32'hF9);
    chk("t6_id",     32'(s3_resp_id), 0);
    nc(); #1;
    chk("t6_idle",   32'(s3_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
